// File: rtl/vx_cache_wb_buffer.sv
// Writeback buffer for dirty cache victims.
// Victim lines from the bank's data store are queued in FIFO order and drained
// as byte-masked write requests on the memory request port. An address lookup
// lets the bank stall a refill whose line still has a writeback pending.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   evict_*           victim line input (valid/ready, addr, data, dirty byte mask)
//   mem_req_*         memory write request output (head of queue)
//   lookup_addr/hit   combinational match against all valid entries
//   empty, full       occupancy status
module vx_cache_wb_buffer #(
  parameter int unsigned LINE_SIZE       = 16,
  parameter int unsigned LINE_ADDR_WIDTH = 26,
  parameter int unsigned NUM_ENTRIES     = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       evict_valid,
  output logic                       evict_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] evict_addr,
  input  logic [LINE_SIZE*8-1:0]     evict_data,
  input  logic [LINE_SIZE-1:0]       evict_byteen,

  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_SIZE*8-1:0]     mem_req_data,
  output logic [LINE_SIZE-1:0]       mem_req_byteen,

  input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
  output logic                       lookup_hit,

  output logic                       empty,
  output logic                       full
);

  localparam int unsigned DataW = LINE_SIZE * 8;
  localparam int unsigned PtrW  = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW  = PtrW + 1;

  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [NUM_ENTRIES-1:0]     valid_q, valid_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q   [NUM_ENTRIES];
  logic [LINE_ADDR_WIDTH-1:0] addr_d   [NUM_ENTRIES];
  logic [DataW-1:0]           data_q   [NUM_ENTRIES];
  logic [DataW-1:0]           data_d   [NUM_ENTRIES];
  logic [LINE_SIZE-1:0]       byteen_q [NUM_ENTRIES];
  logic [LINE_SIZE-1:0]       byteen_d [NUM_ENTRIES];

  logic push, store, pop;
  logic dup_hit;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(NUM_ENTRIES));

  // No bypass: a pop while full frees the slot only from the next cycle on.
  assign evict_ready = ~full & ~reset;
  assign push        = evict_valid & evict_ready;
  // Clean victims complete the handshake but are dropped.
  assign store       = push & (|evict_byteen);

  assign mem_req_valid  = ~empty;
  assign mem_req_addr   = addr_q[rd_ptr_q];
  assign mem_req_data   = data_q[rd_ptr_q];
  assign mem_req_byteen = byteen_q[rd_ptr_q];
  assign pop            = mem_req_valid & mem_req_ready;

  // Lookup sees registered state only, so an entry being written this cycle is
  // invisible and the head being popped this cycle still hits.
  always_comb begin
    lookup_hit = 1'b0;
    dup_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[PtrW'(i)] && (addr_q[PtrW'(i)] == lookup_addr)) lookup_hit = 1'b1;
      if (valid_q[PtrW'(i)] && (addr_q[PtrW'(i)] == evict_addr))  dup_hit    = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    byteen_d = byteen_q;
    count_d  = count_q + CntW'(store) - CntW'(pop);

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    // Never the same slot as the pop: store requires not full, pop requires not empty.
    if (store) begin
      valid_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q]   = evict_addr;
      data_d[wr_ptr_q]   = evict_data;
      byteen_d[wr_ptr_q] = evict_byteen;
      wr_ptr_d           = wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset; it is qualified by valid_q and the count.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    data_q   <= data_d;
    byteen_q <= byteen_d;
  end

  // The bank must block refills of pending lines, so a duplicate is a bank bug.
  a_no_dup: assert property (@(posedge clk) disable iff (reset) store |-> !dup_hit);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) store |-> (!full || pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) pop |-> !empty);
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
      (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable(mem_req_addr) && $stable(mem_req_data)
       && $stable(mem_req_byteen)));

endmodule

// File: tb/tb_vx_cache_wb_buffer.sv
// Bench for vx_cache_wb_buffer: a queue-based reference model checked at every
// falling edge, plus directed scenarios with literal expectations.
module tb_vx_cache_wb_buffer;

  localparam int unsigned LS = 16;
  localparam int unsigned AW = 26;
  localparam int unsigned N  = 4;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [LS*8-1:0] data;
    logic [LS-1:0]   be;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            evict_valid;
  logic            evict_ready;
  logic [AW-1:0]   evict_addr;
  logic [LS*8-1:0] evict_data;
  logic [LS-1:0]   evict_byteen;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [LS*8-1:0] mem_req_data;
  logic [LS-1:0]   mem_req_byteen;
  logic [AW-1:0]   lookup_addr;
  logic            lookup_hit;
  logic            empty;
  logic            full;

  vx_cache_wb_buffer #(
    .LINE_SIZE(LS), .LINE_ADDR_WIDTH(AW), .NUM_ENTRIES(N)
  ) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr),
    .evict_data(evict_data), .evict_byteen(evict_byteen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_byteen(mem_req_byteen),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  ent_t q[$];
  logic [AW-1:0] popped[$];
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [LS*8-1:0] got,
                       input logic [LS*8-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model compare: outputs follow from the queue contents alone.
  task automatic compare();
    bit hit;
    hit = 1'b0;
    foreach (q[i]) if (q[i].addr == lookup_addr) hit = 1'b1;
    check("m_valid", mem_req_valid, (q.size() != 0));
    check("m_empty", empty, (q.size() == 0));
    check("m_full", full, (q.size() == N));
    check("m_evict_ready", evict_ready, (!reset && q.size() < N));
    check("m_lookup_hit", lookup_hit, hit);
    if (q.size() != 0) begin
      check("m_addr", mem_req_addr, q[0].addr);
      check("m_data", mem_req_data, q[0].data);
      check("m_byteen", mem_req_byteen, q[0].be);
    end
    if (!reset && mem_req_valid && mem_req_ready) popped.push_back(mem_req_addr);
  endtask

  task automatic update_model();
    bit do_push, do_pop;
    if (reset) begin
      q.delete();
      model_on = 1'b1;
    end else begin
      do_push = evict_valid && (q.size() < N) && (evict_byteen != '0);
      do_pop  = (q.size() != 0) && mem_req_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{addr: evict_addr, data: evict_data, be: evict_byteen});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) compare();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [LS*8-1:0] d,
                       input logic [LS-1:0] be);
    evict_valid  = 1'b1;
    evict_addr   = a;
    evict_data   = d;
    evict_byteen = be;
  endtask

  initial begin
    logic [LS*8-1:0] a5;
    a5 = {LS{8'hA5}};
    reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    evict_byteen = '0; mem_req_ready = 1'b0; lookup_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_evict_ready", evict_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", mem_req_valid, 0);
    check("rst_hit", lookup_hit, 0);

    // Single dirty line, stalled, then drained.
    offer(26'h100, a5, 16'hFFFF);
    lookup_addr = 26'h100;
    #1 check("t1_hit_same_cycle", lookup_hit, 0);
    tick();
    evict_valid = 1'b0;
    check("t1_valid", mem_req_valid, 1);
    check("t1_addr", mem_req_addr, 26'h100);
    check("t1_byteen", mem_req_byteen, 16'hFFFF);
    check("t1_data", mem_req_data, a5);
    check("t1_hit", lookup_hit, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_hold_addr", mem_req_addr, 26'h100);
    end
    mem_req_ready = 1'b1;
    #1 check("t1_hit_pop_cycle", lookup_hit, 1);
    tick();
    mem_req_ready = 1'b0;
    check("t1_empty", empty, 1);
    check("t1_hit_after", lookup_hit, 0);

    // Clean victim: handshake only.
    offer(26'h200, '0, 16'h0000);
    lookup_addr = 26'h200;
    #1 check("t2_ready", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    check("t2_empty", empty, 1);
    check("t2_hit", lookup_hit, 0);

    // Fill, no-bypass when full, then drain in order.
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      offer(26'h10 + AW'(i), LS*8'(i + 1), 16'hFFFF);
      tick();
    end
    evict_valid = 1'b0;
    check("t3_full", full, 1);
    check("t3_ready", evict_ready, 0);
    offer(26'h14, LS*8'(5), 16'hFFFF);
    mem_req_ready = 1'b1;
    #1 check("t3_ready_while_pop", evict_ready, 0);
    tick();
    mem_req_ready = 1'b0;
    check("t3_ready_next", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10 && !empty; i++) tick();
    mem_req_ready = 1'b0;
    check("t3_drained", empty, 1);
    check("t3_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check("t3_order", popped[i], 26'h10 + AW'(i));

    // Steady stream: push and pop every cycle, pointers wrap twice.
    popped.delete();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(26'h300 + AW'(i), LS*8'(i * 7), 16'h000F);
      tick();
      check("t4_one_entry", {empty, full}, 2'b00);
    end
    evict_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    check("t4_empty", empty, 1);
    check("t4_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check("t4_order", popped[i], 26'h300 + AW'(i));

    // Reset discards queued entries.
    popped.delete();
    for (int i = 0; i < 3; i++) begin
      offer(26'h50 + AW'(i), LS*8'(i), 16'h00FF);
      tick();
    end
    evict_valid = 1'b0;
    reset = 1'b1;
    #1 check("t5_ready_in_reset", evict_ready, 0);
    tick();
    reset = 1'b0;
    check("t5_valid", mem_req_valid, 0);
    check("t5_empty", empty, 1);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_req_ready = 1'b0;
    check("t5_no_req", popped.size(), 0);

    // Lookup visibility around push and pop.
    offer(26'h40, {LS{8'h3C}}, 16'h1234);
    lookup_addr = 26'h40;
    #1 check("t6_hit_push", lookup_hit, 0);
    tick();
    evict_valid = 1'b0;
    check("t6_hit_next", lookup_hit, 1);
    mem_req_ready = 1'b1;
    #1 check("t6_hit_pop", lookup_hit, 1);
    tick();
    mem_req_ready = 1'b0;
    check("t6_hit_after", lookup_hit, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vx_cache_wb_buffer.md
Name: VX_cache_wb_buffer

Overview:
- Eviction/writeback buffer that sits directly downstream of the cache bank data store in writeback mode.
- Accepts each victim line together with its dirty-byte mask.
- Queues dirty victims in FIFO order and issues them as byte-masked write requests to the memory-side request port.
- Provides a combinational address lookup so the bank stalls a refill of a line whose writeback is still pending.

Parameters:
- LINE_SIZE, 16, line size in bytes; line data width is LINE_SIZE*8.
- LINE_ADDR_WIDTH, 26, width of a line-granular address.
- NUM_ENTRIES, 4, buffer depth; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- evict_valid  in  1  victim line offered by the bank
- evict_ready  out  1  buffer can accept a victim this cycle
- evict_addr  in  LINE_ADDR_WIDTH  victim line address
- evict_data  in  LINE_SIZE*8  victim line data (evicted_data from the data store)
- evict_byteen  in  LINE_SIZE  victim dirty-byte mask (write_byteen from the data store)
- mem_req_valid  out  1  head entry is valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  LINE_ADDR_WIDTH  head line address
- mem_req_data  out  LINE_SIZE*8  head line data
- mem_req_byteen  out  LINE_SIZE  head dirty mask
- lookup_addr  in  LINE_ADDR_WIDTH  address of a pending fill/miss
- lookup_hit  out  1  lookup_addr matches a valid entry
- empty  out  1  no valid entries
- full  out  1  all entries valid

Behaviour:
- Storage: circular FIFO with rd_ptr and wr_ptr of log2(NUM_ENTRIES) bits, wrap modulo NUM_ENTRIES.
- Occupancy counter: log2(NUM_ENTRIES)+1 bits.
- Per-entry valid bit, addr, data, byteen.
- Reset:
  - Pointers, count and all valid bits clear.
  - Outputs after reset: mem_req_valid=0, empty=1, full=0, lookup_hit=0, evict_ready=1.
  - While reset is high, evict_ready=0.
  - Reset mid-operation discards all queued entries; no memory request is issued for them.
- evict_ready = ~full. There is no same-cycle bypass: when full, a simultaneous pop does not open a slot until the next cycle.
- push = evict_valid & evict_ready.
  - If evict_byteen != 0, write the entry at wr_ptr, set it valid, increment wr_ptr.
  - If evict_byteen == 0 (clean victim), the handshake completes but nothing is stored: no pointer or count change.
- mem_req_valid = ~empty. mem_req_addr, mem_req_data and mem_req_byteen are driven from the entry at rd_ptr (registered storage, combinational read).
- Outputs stay stable while mem_req_valid & ~mem_req_ready.
- pop = mem_req_valid & mem_req_ready: clear the valid bit at rd_ptr and increment rd_ptr.
- Count update: count += stored_push - pop.
  - A simultaneous push and pop (not full) leaves the count unchanged.
  - A push into an empty buffer gives mem_req_valid=1 in the next cycle (1-cycle latency).
- lookup_hit = OR over entries of (valid & addr == lookup_addr); purely combinational.
  - An entry accepted this cycle is not visible until the next cycle.
  - The head entry being popped this cycle still reports a hit this cycle.
- Ordering: strict FIFO; writes issue oldest-first.
- No coalescing. The bank never evicts the same line address twice while an entry is pending, because its refill is blocked by lookup_hit.
- Assertions (simulation only):
  - A stored push whose address matches a valid entry is an error.
  - Overflow and underflow are errors.
  - mem_req outputs must not change while stalled.
- empty = (count == 0); full = (count == NUM_ENTRIES).

Test Plan:
- Reset, then push addr=0x100, data=0xA5..A5, byteen=0xFFFF with mem_req_ready=0 -> next cycle mem_req_valid=1, addr=0x100, byteen=0xFFFF; outputs held 3 cycles; lookup_addr=0x100 -> hit=1. Raise ready -> pop; next cycle empty=1, hit=0.
- Push with byteen=0x0000, addr=0x200 -> evict_ready=1, handshake completes, empty stays 1, lookup 0x200 -> hit=0.
- Push 4 dirty lines 0x10..0x13 with ready=0 -> full=1, evict_ready=0. Offer 0x14 while popping -> 0x14 not accepted that cycle, accepted the next. Drain order is 0x10, 0x11, 0x12, 0x13, 0x14.
- Steady stream with push and pop every cycle, 10 lines, byteen=0x000F -> count stays at 1; all 10 addresses appear in order; pointers wrap twice without loss.
- Assert reset with 3 entries queued -> next cycle mem_req_valid=0, empty=1, and no request for the discarded entries ever appears.
- Push 0x40 and, in the same cycle, look up 0x40 -> hit=0; next cycle hit=1; during the popping cycle hit=1; the cycle after the pop hit=0.
